// File: rtl/cr_writeback.sv
// Condition-register writeback stage.
// Compare results arrive on the wb port, wait in a 2-entry in-order FIFO, and
// are broadcast from the head on the cdb port. A cdb handshake commits the
// 4-bit result into its field of the 32-bit CR. Field f occupies
// cr[4*f : 4*f+3], where bit 0 is the MSB.
module cr_writeback #(
  parameter int RS_ID_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_valid,
  output logic                   wb_ready,
  input  logic [RS_ID_WIDTH-1:0] wb_rs_id,
  input  logic [0:2]             wb_field_addr,
  input  logic [0:3]             wb_result,
  input  logic                   flush,
  output logic                   cdb_valid,
  input  logic                   cdb_ready,
  output logic [RS_ID_WIDTH-1:0] cdb_rs_id,
  output logic [0:2]             cdb_field_addr,
  output logic [0:3]             cdb_value,
  input  logic [0:2]             rd_field_addr,
  output logic [0:3]             rd_value,
  output logic                   rd_pending,
  output logic [0:31]            cr
);

  localparam int DEPTH = 2;

  // FIFO storage. Slot 0 is always the head, and slot 1 is the younger entry.
  logic [RS_ID_WIDTH-1:0] id_q  [DEPTH];
  logic [RS_ID_WIDTH-1:0] id_d  [DEPTH];
  logic [0:2]             fa_q  [DEPTH];
  logic [0:2]             fa_d  [DEPTH];
  logic [0:3]             res_q [DEPTH];
  logic [0:3]             res_d [DEPTH];
  logic [1:0]             count_q;
  logic [1:0]             count_d;
  logic [0:31]            cr_q;
  logic [0:31]            cr_d;

  logic             push;
  logic             pop;
  logic [DEPTH-1:0] slot_vld;
  logic [DEPTH-1:0] slot_match;

  // Handshake qualifiers. wb_ready comes only from the occupancy register.
  assign wb_ready  = (count_q < 2'd2);
  assign cdb_valid = (count_q != 2'd0);
  assign push      = wb_valid && wb_ready && !flush;
  assign pop       = cdb_valid && cdb_ready;

  // Per-slot validity and read-port field match, used to build rd_pending.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign slot_vld[gi]   = (count_q > 2'(gi));
      assign slot_match[gi] = slot_vld[gi] && (fa_q[gi] == rd_field_addr);
    end
  endgenerate

  // The head is masked when the FIFO is empty, so that stale slot contents never leak out.
  assign cdb_rs_id      = cdb_valid ? id_q[0]  : '0;
  assign cdb_field_addr = cdb_valid ? fa_q[0]  : '0;
  assign cdb_value      = cdb_valid ? res_q[0] : '0;

  // The read port sees committed state only. In-flight entries are reported via rd_pending.
  assign rd_value   = cr_q[{rd_field_addr, 2'b00} +: 4];
  assign rd_pending = |slot_match;
  assign cr         = cr_q;

  // Next-state logic: commit the head on pop, then update the FIFO (flush wins over push).
  always_comb begin
    id_d    = id_q;
    fa_d    = fa_q;
    res_d   = res_q;
    count_d = count_q;
    cr_d    = cr_q;

    if (pop) begin
      cr_d[{fa_q[0], 2'b00} +: 4] = res_q[0];
    end

    if (flush) begin
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            id_d[0]  = wb_rs_id;
            fa_d[0]  = wb_field_addr;
            res_d[0] = wb_result;
            count_d  = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            // The old head leaves and the new entry becomes the head. Occupancy does not change.
            id_d[0]  = wb_rs_id;
            fa_d[0]  = wb_field_addr;
            res_d[0] = wb_result;
          end else if (push) begin
            id_d[1]  = wb_rs_id;
            fa_d[1]  = wb_field_addr;
            res_d[1] = wb_result;
            count_d  = 2'd2;
          end else if (pop) begin
            count_d = 2'd0;
          end
        end
        2'd2: begin
          // wb_ready is low when the FIFO is full, so only a pop can happen here.
          if (pop) begin
            id_d[0]  = id_q[1];
            fa_d[0]  = fa_q[1];
            res_d[0] = res_q[1];
            count_d  = 2'd1;
          end
        end
        default: begin
          count_d = 2'd0;
        end
      endcase
    end
  end

  // State registers. Reset clears the FIFO and CR, and overrides every other update.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      cr_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i]  <= '0;
        fa_q[i]  <= '0;
        res_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      cr_q    <= cr_d;
      id_q    <= id_d;
      fa_q    <= fa_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_cr_writeback.sv
// Testbench for cr_writeback. It runs directed scenarios and then a randomized run.
// All runs are checked against a queue-based model of the FIFO and CR.
module tb_cr_writeback;

  localparam int W = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_valid;
  logic          wb_ready;
  logic [W-1:0]  wb_rs_id;
  logic [0:2]    wb_field_addr;
  logic [0:3]    wb_result;
  logic          flush;
  logic          cdb_valid;
  logic          cdb_ready;
  logic [W-1:0]  cdb_rs_id;
  logic [0:2]    cdb_field_addr;
  logic [0:3]    cdb_value;
  logic [0:2]    rd_field_addr;
  logic [0:3]    rd_value;
  logic          rd_pending;
  logic [0:31]   cr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [W-1:0] id;
    logic [2:0]   f;
    logic [3:0]   r;
  } ent_t;

  ent_t        mq[$];
  logic [0:31] mcr;

  always #5 clk = ~clk;

  cr_writeback #(.RS_ID_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rs_id(wb_rs_id),
    .wb_field_addr(wb_field_addr), .wb_result(wb_result),
    .flush(flush),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_rs_id(cdb_rs_id),
    .cdb_field_addr(cdb_field_addr), .cdb_value(cdb_value),
    .rd_field_addr(rd_field_addr), .rd_value(rd_value), .rd_pending(rd_pending),
    .cr(cr)
  );

  // Advance one clock. The model applies the current inputs with the same
  // rules as the DUT: a pop commits the oldest entry, flush empties the queue,
  // and a push is accepted only when there is room.
  task automatic tick();
    bit   push;
    bit   pop;
    ent_t e;
    push = wb_valid && (mq.size() < 2) && !flush;
    pop  = (mq.size() > 0) && cdb_ready;
    if (rst) begin
      mq.delete();
      mcr = '0;
    end else begin
      if (pop) begin
        e = mq.pop_front();
        mcr[4*e.f +: 4] = e.r;
      end
      if (flush) mq.delete();
      else if (push) begin
        e.id = wb_rs_id; e.f = wb_field_addr; e.r = wb_result;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic v, input logic [W-1:0] id, input logic [2:0] f, input logic [3:0] r);
    wb_valid = v; wb_rs_id = id; wb_field_addr = f; wb_result = r;
  endtask

  task automatic do_reset();
    rst = 1'b1; drive_wb(1'b0, '0, '0, '0); flush = 1'b0; cdb_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rd_field_addr = 3'd0;
    #1;
    n_checks++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wb_ready: got %b want 1", wb_ready); end
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cdb_valid: got %b want 0", cdb_valid); end
    n_checks++; if (cdb_rs_id !== '0) begin n_fail++; $display("FAIL reset_cdb_rs_id: got %0d want 0", cdb_rs_id); end
    n_checks++; if (cdb_field_addr !== 3'd0) begin n_fail++; $display("FAIL reset_cdb_field: got %0d want 0", cdb_field_addr); end
    n_checks++; if (cdb_value !== 4'd0) begin n_fail++; $display("FAIL reset_cdb_value: got %b want 0000", cdb_value); end
    n_checks++; if (rd_pending !== 1'b0) begin n_fail++; $display("FAIL reset_rd_pending: got %b want 0", rd_pending); end
    n_checks++; if (cr !== 32'h0) begin n_fail++; $display("FAIL reset_cr: got %h want 00000000", cr); end
    $display("reset: cr=%h wb_ready=%b cdb_valid=%b", cr, wb_ready, cdb_valid);
  endtask

  task automatic test_single_write();
    cdb_ready = 1'b1;
    drive_wb(1'b1, 5'd3, 3'd2, 4'b1000);
    tick();
    drive_wb(1'b0, '0, '0, '0);
    n_checks++; if (cdb_valid !== 1'b1) begin n_fail++; $display("FAIL single_cdb_valid: got %b want 1", cdb_valid); end
    n_checks++; if (cdb_rs_id !== 5'd3) begin n_fail++; $display("FAIL single_cdb_rs_id: got %0d want 3", cdb_rs_id); end
    n_checks++; if (cr !== 32'h0) begin n_fail++; $display("FAIL single_cr_early: got %h want 00000000", cr); end
    tick();
    n_checks++; if (cr !== 32'h0080_0000) begin n_fail++; $display("FAIL single_cr: got %h want 00800000", cr); end
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL single_cdb_empty: got %b want 0", cdb_valid); end
    $display("single write: cr=%h", cr);
  endtask

  task automatic test_backpressure();
    do_reset();
    cdb_ready = 1'b0;
    drive_wb(1'b1, 5'd1, 3'd0, 4'b1010);
    tick();
    n_checks++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after1: got %b want 1", wb_ready); end
    drive_wb(1'b1, 5'd2, 3'd1, 4'b0101);
    tick();
    n_checks++; if (wb_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_after2: got %b want 0", wb_ready); end
    drive_wb(1'b1, 5'd3, 3'd3, 4'b1111);
    tick();
    n_checks++; if (wb_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b want 0", wb_ready); end
    n_checks++; if (cdb_rs_id !== 5'd1) begin n_fail++; $display("FAIL bp_head_stable: got %0d want 1", cdb_rs_id); end
    drive_wb(1'b0, '0, '0, '0);
    cdb_ready = 1'b1;
    tick();
    n_checks++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop: got %b want 1", wb_ready); end
    n_checks++; if (cdb_rs_id !== 5'd2) begin n_fail++; $display("FAIL bp_second_head: got %0d want 2", cdb_rs_id); end
    n_checks++; if (cr !== 32'hA000_0000) begin n_fail++; $display("FAIL bp_cr_first: got %h want a0000000", cr); end
    tick();
    n_checks++; if (cr !== 32'hA500_0000) begin n_fail++; $display("FAIL bp_cr_second: got %h want a5000000", cr); end
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", cdb_valid); end
    $display("backpressure: cr=%h", cr);
  endtask

  task automatic test_same_field();
    cdb_ready = 1'b1;
    drive_wb(1'b1, 5'd4, 3'd7, 4'b0100);
    tick();
    drive_wb(1'b1, 5'd5, 3'd7, 4'b0010);
    tick();
    drive_wb(1'b0, '0, '0, '0);
    n_checks++; if (cr[28:31] !== 4'b0100) begin n_fail++; $display("FAIL same_first_commit: got %b want 0100", cr[28:31]); end
    n_checks++; if (cdb_rs_id !== 5'd5) begin n_fail++; $display("FAIL same_push_pop_head: got %0d want 5", cdb_rs_id); end
    tick();
    n_checks++; if (cr[28:31] !== 4'b0010) begin n_fail++; $display("FAIL same_final: got %b want 0010", cr[28:31]); end
    n_checks++; if (cr !== 32'hA500_0002) begin n_fail++; $display("FAIL same_other_fields: got %h want a5000002", cr); end
    $display("same field: cr=%h", cr);
  endtask

  task automatic test_pending_read();
    cdb_ready = 1'b1;
    drive_wb(1'b1, 5'd9, 3'd5, 4'b1100);
    tick();
    drive_wb(1'b0, '0, '0, '0);
    tick();
    cdb_ready = 1'b0;
    drive_wb(1'b1, 5'd10, 3'd5, 4'b0011);
    tick();
    drive_wb(1'b0, '0, '0, '0);
    rd_field_addr = 3'd5;
    #1;
    n_checks++; if (rd_pending !== 1'b1) begin n_fail++; $display("FAIL pend_high: got %b want 1", rd_pending); end
    n_checks++; if (rd_value !== 4'b1100) begin n_fail++; $display("FAIL pend_old_value: got %b want 1100", rd_value); end
    rd_field_addr = 3'd4;
    #1;
    n_checks++; if (rd_pending !== 1'b0) begin n_fail++; $display("FAIL pend_other_field: got %b want 0", rd_pending); end
    rd_field_addr = 3'd5;
    cdb_ready = 1'b1;
    tick();
    n_checks++; if (rd_pending !== 1'b0) begin n_fail++; $display("FAIL pend_cleared: got %b want 0", rd_pending); end
    n_checks++; if (rd_value !== 4'b0011) begin n_fail++; $display("FAIL pend_new_value: got %b want 0011", rd_value); end
    $display("pending/read: rd_value=%b cr=%h", rd_value, cr);
  endtask

  task automatic test_flush();
    cdb_ready = 1'b0;
    drive_wb(1'b1, 5'd7, 3'd1, 4'b1001);
    tick();
    drive_wb(1'b1, 5'd8, 3'd6, 4'b0110);
    tick();
    flush = 1'b1; cdb_ready = 1'b1;
    drive_wb(1'b1, 5'd11, 3'd2, 4'b1111);
    tick();
    flush = 1'b0;
    drive_wb(1'b0, '0, '0, '0);
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got %b want 0", cdb_valid); end
    n_checks++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL flush_wb_ready: got %b want 1", wb_ready); end
    n_checks++; if (cr[4:7] !== 4'b1001) begin n_fail++; $display("FAIL flush_head_commit: got %b want 1001", cr[4:7]); end
    n_checks++; if (cr[24:27] !== 4'b0000) begin n_fail++; $display("FAIL flush_discard: got %b want 0000", cr[24:27]); end
    flush = 1'b1;
    drive_wb(1'b1, 5'd12, 3'd3, 4'b1111);
    tick();
    flush = 1'b0;
    drive_wb(1'b0, '0, '0, '0);
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop_push: got %b want 0", cdb_valid); end
    n_checks++; if (cr !== mcr) begin n_fail++; $display("FAIL flush_cr_model: got %h want %h", cr, mcr); end
    $display("flush: cr=%h", cr);
  endtask

  task automatic test_reset_mid();
    cdb_ready = 1'b0;
    drive_wb(1'b1, 5'd13, 3'd0, 4'b0001);
    tick();
    drive_wb(1'b1, 5'd14, 3'd4, 4'b0111);
    tick();
    rst = 1'b1; cdb_ready = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    drive_wb(1'b0, '0, '0, '0);
    n_checks++; if (cr !== 32'h0) begin n_fail++; $display("FAIL rstmid_cr: got %h want 00000000", cr); end
    n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_cdb_valid: got %b want 0", cdb_valid); end
    n_checks++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_wb_ready: got %b want 1", wb_ready); end
    tick();
    n_checks++; if (cr !== 32'h0) begin n_fail++; $display("FAIL rstmid_no_commit: got %h want 00000000", cr); end
    $display("reset mid-run: cr=%h", cr);
  endtask

  task automatic test_random();
    logic [W-1:0] exp_id;
    logic [2:0]   exp_f;
    logic [3:0]   exp_r;
    logic         exp_pend;
    int           errs;
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 59) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      cdb_ready = ($urandom_range(0, 9) < 6);
      drive_wb($urandom_range(0, 1) == 1, W'($urandom), 3'($urandom), 4'($urandom));
      rd_field_addr = 3'($urandom);
      #1;
      exp_id = '0; exp_f = '0; exp_r = '0;
      if (mq.size() > 0) begin exp_id = mq[0].id; exp_f = mq[0].f; exp_r = mq[0].r; end
      exp_pend = 1'b0;
      foreach (mq[k]) if (mq[k].f == rd_field_addr) exp_pend = 1'b1;
      errs = n_fail;
      n_checks++; if (wb_ready !== (mq.size() < 2)) begin n_fail++; $display("FAIL rnd_wb_ready c=%0d: got %b want %b", c, wb_ready, mq.size() < 2); end
      n_checks++; if (cdb_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_cdb_valid c=%0d: got %b want %b", c, cdb_valid, mq.size() > 0); end
      n_checks++; if ({cdb_rs_id, cdb_field_addr, cdb_value} !== {exp_id, exp_f, exp_r}) begin n_fail++; $display("FAIL rnd_cdb c=%0d: got id=%0d f=%0d v=%b want id=%0d f=%0d v=%b", c, cdb_rs_id, cdb_field_addr, cdb_value, exp_id, exp_f, exp_r); end
      n_checks++; if (cr !== mcr) begin n_fail++; $display("FAIL rnd_cr c=%0d: got %h want %h", c, cr, mcr); end
      n_checks++; if (rd_value !== mcr[4*rd_field_addr +: 4]) begin n_fail++; $display("FAIL rnd_rd_value c=%0d: got %b want %b", c, rd_value, mcr[4*rd_field_addr +: 4]); end
      n_checks++; if (rd_pending !== exp_pend) begin n_fail++; $display("FAIL rnd_rd_pending c=%0d: got %b want %b", c, rd_pending, exp_pend); end
      if (c % 50 == 0) $display("random c=%0d occ=%0d cr=%h new_fail=%0d", c, mq.size(), cr, n_fail - errs);
      tick();
    end
    rst = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; cdb_ready = 1'b0; rd_field_addr = 3'd0;
    drive_wb(1'b0, '0, '0, '0);
    mcr = '0;
    test_reset();
    test_single_write();
    test_backpressure();
    test_same_field();
    test_pending_read();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
